count_seq_ctrl: RTL and testbench
=================================

Name: count_seq_ctrl

Overview:
Sequencing controller for the team's 4-bit up/down counter datapath. It accepts "count to target" commands over a valid/ready handshake, optionally clears the counter first, and then drives the counter's enable and direction one step at a time until the observed count equals the target, wrapping at the ends. It sits between the command/CPU-side logic and a counter instance that has an enable input. It reports busy, done, abort status and the step count.

Parameters:
WIDTH, 4, counter width; target, observed count and step counter are sized from it.
PRESCALE, 4, cycles per counter step; only used when COUNT_PRESCALE_EN is defined; legal range >= 1.

Ports:
Clk  input  1  rising-edge clock.
reset_n  input  1  synchronous, active-low reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  controller can accept a command (high only in IDLE and while reset_n=1).
cmd_up  input  1  direction: 1 = up, 0 = down.
cmd_clear  input  1  clear the counter to 0 before stepping.
cmd_target  input  WIDTH  count value to stop at.
abort  input  1  terminate the active command.
cnt_value  input  WIDTH  current value of the controlled counter.
cnt_en  output  1  counter steps on the next Clk edge.
cnt_up  output  1  direction to the counter; valid when cnt_en=1.
cnt_clr  output  1  synchronous clear to the counter.
busy  output  1  high in CLEAR, RUN and DONE.
done  output  1  one-cycle pulse when a command finishes.
aborted  output  1  valid with done; 1 = the command ended by abort.
steps  output  WIDTH+1  number of cnt_en pulses issued for the last or current command.

Behaviour:
- Reset (reset_n=0 at a Clk edge):
  - state = IDLE.
  - done = aborted = 0, steps = 0, latched dir/target = 0.
  - cnt_en = cnt_clr = 0.
  - cmd_ready = 0 while reset_n is low.
- Accept: cmd_valid & cmd_ready at an edge.
  - Latch cmd_up, cmd_target; clear steps.
  - Next state is CLEAR if cmd_clear=1, else RUN.
  - cmd_valid while not ready is ignored; the requester holds it.
- States:
  - IDLE: cmd_ready=1; all other control outputs 0.
  - CLEAR: cnt_clr=1 for exactly one cycle, then RUN.
  - RUN, each cycle:
    - if cnt_value == target: go to DONE; cnt_en=0.
    - else: cnt_en=1, cnt_up=latched dir, steps+1; stay in RUN.
    - The comparison uses the current cnt_value, so the counter never steps past the target.
  - DONE: done=1 for one cycle, then IDLE. aborted holds its value until the next accept.
- Output timing:
  - cnt_en and cnt_clr are combinational from state and cnt_value (no register stage).
  - done, aborted and steps are registered.
- Wrap-around: the controller does not special-case wrap; the counter wraps 15->0 (up) and 0->15 (down). The worst case is 2^WIDTH-1 steps.
- Already at target on entry to RUN: zero steps, DONE the next cycle.
- Latency:
  - Accept at cycle T, no clear, distance d: done is high at T+d+2.
  - With clear: T+d+3, where d is measured from 0.
- Abort:
  - In CLEAR or RUN: cnt_en=0 that cycle, go to DONE with aborted=1; steps keeps the count so far.
  - In IDLE or DONE: ignored.
  - Abort takes priority over target match in the same cycle.
- Reset mid-command: immediate return to IDLE; no done pulse.

Optional Feature:
COUNT_PRESCALE_EN
- Defined:
  - In RUN, cnt_en is asserted only when an internal prescale counter equals PRESCALE-1.
  - The prescale counter is zeroed on entry to RUN and wraps after each step.
  - The target compare and abort are still evaluated every cycle.
  - Latency without clear becomes T+d*PRESCALE+2.
- Not defined: no prescale logic; one step per cycle in RUN; PRESCALE is ignored.

Test Plan:
1. Reset, then command up, no clear, target 5, with the counter model at 3 -> cnt_en high for 2 cycles, cnt_up=1, done pulse at T+4, steps=2, aborted=0.
2. Command down, target 14, counter at 1 -> wraps 1,0,15,14; 3 steps; done with steps=3.
3. Command with cmd_clear=1, up, target 0 -> one cnt_clr cycle, zero steps, done at T+3, steps=0.
4. Command up, target 10, counter at 0; abort raised after 4 steps -> no 5th cnt_en; done pulse with aborted=1, steps=4; cmd_ready=1 the next cycle.
5. reset_n low during RUN -> state IDLE at the next edge; cnt_en=0, no done, steps=0; cmd_valid held during reset is not accepted.
6. With COUNT_PRESCALE_EN, PRESCALE=4: up, 2->4 -> cnt_en pulses 4 cycles apart, done at T+10, steps=2.

Source files
------------

// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: sequencing controller for a WIDTH-bit up/down counter.
// Accepts "count to target" commands on a valid/ready handshake, can clear the
// counter first, then issues one enable per step until the observed count
// equals the latched target. Wrap-around is left to the counter itself.
//
// Build option: define COUNT_PRESCALE_EN to space counter steps PRESCALE
// cycles apart in RUN. Without it the controller steps once per RUN cycle.
module count_seq_ctrl #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 4
) (
    input  logic             Clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_up,
    input  logic             cmd_clear,
    input  logic [WIDTH-1:0] cmd_target,
    input  logic             abort,
    input  logic [WIDTH-1:0] cnt_value,
    output logic             cnt_en,
    output logic             cnt_up,
    output logic             cnt_clr,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [WIDTH:0]   steps
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_dir;
    logic [WIDTH-1:0]   r_target;
    logic               r_busy;
    logic               r_done;
    logic               r_aborted;
    logic [WIDTH:0]     r_steps;

    logic               w_accept;
    logic               w_match;
    logic               w_tick;
    logic               w_step;

    // Ready is forced low while reset is held so nothing is accepted then.
    assign cmd_ready = reset_n && (r_state == S_IDLE);
    assign w_accept  = cmd_valid && cmd_ready;

    // Compare against the live counter value so we never step past target.
    assign w_match   = (cnt_value == r_target);

`ifdef COUNT_PRESCALE_EN
    localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] r_pre;

    assign w_tick = (r_pre == PRE_LAST);

    // Prescale divider: held at zero outside RUN, so RUN always starts a
    // fresh PRESCALE-cycle interval; wraps after every step slot.
    always_ff @(posedge Clk) begin
        if (!reset_n) begin
            r_pre <= '0;
        end else if (r_state != S_RUN) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PW'(1);
        end
    end
`else
    // Every RUN cycle is a step slot; PRESCALE only acts as a legality guard
    // here (a value below 1 would stall stepping).
    assign w_tick = (PRESCALE >= 1);
`endif

    // A step happens only in RUN, not on abort, not at target, on a slot.
    assign w_step  = (r_state == S_RUN) && !abort && !w_match && w_tick;

    // Counter controls are combinational so a step lands on the next edge.
    assign cnt_en  = w_step;
    assign cnt_clr = (r_state == S_CLEAR) && !abort;
    assign cnt_up  = r_dir;

    assign busy    = r_busy;
    assign done    = r_done;
    assign aborted = r_aborted;
    assign steps   = r_steps;

    // Command FSM with registered status outputs.
    always_ff @(posedge Clk) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_dir     <= 1'b0;
            r_target  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_steps   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_dir     <= cmd_up;
                        r_target  <= cmd_target;
                        r_steps   <= '0;
                        r_aborted <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= cmd_clear ? S_CLEAR : S_RUN;
                    end
                end
                S_CLEAR: begin
                    if (abort) begin
                        r_aborted <= 1'b1;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Abort wins over a simultaneous target match.
                    if (abort) begin
                        r_aborted <= 1'b1;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end else if (w_match) begin
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end else if (w_tick) begin
                        r_steps   <= r_steps + (WIDTH+1)'(1);
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Bench for count_seq_ctrl: a behavioural 4-bit counter closes the loop; each
// command pushes its expected result (done cycle, steps, aborted, pulse counts)
// and the entry is popped and compared when done is seen.
module tb_count_seq_ctrl;

    localparam int WIDTH    = 4;
    localparam int PRESCALE = 4;
`ifdef COUNT_PRESCALE_EN
    localparam int S = PRESCALE;
`else
    localparam int S = 1;
`endif

    logic             Clk = 1'b0;
    logic             reset_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_up;
    logic             cmd_clear;
    logic [WIDTH-1:0] cmd_target;
    logic             abort;
    logic [WIDTH-1:0] cnt_value;
    logic             cnt_en;
    logic             cnt_up;
    logic             cnt_clr;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [WIDTH:0]   steps;

    always #5 Clk = ~Clk;

    count_seq_ctrl #(.WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
        .Clk(Clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_up(cmd_up), .cmd_clear(cmd_clear), .cmd_target(cmd_target),
        .abort(abort), .cnt_value(cnt_value), .cnt_en(cnt_en), .cnt_up(cnt_up),
        .cnt_clr(cnt_clr), .busy(busy), .done(done), .aborted(aborted), .steps(steps)
    );

    // Counter model with a bench-side preload.
    logic             ld;
    logic [WIDTH-1:0] ld_val;
    logic [WIDTH-1:0] mcnt;
    logic             exp_dir;
    int               cyc = 0;
    int               en_tot = 0;
    int               clr_tot = 0;
    int               dir_err = 0;

    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (ld)           mcnt <= ld_val;
        else if (cnt_clr) mcnt <= '0;
        else if (cnt_en)  mcnt <= cnt_up ? mcnt + 4'd1 : mcnt - 4'd1;
        if (cnt_en === 1'b1)  en_tot  <= en_tot + 1;
        if (cnt_clr === 1'b1) clr_tot <= clr_tot + 1;
        if (cnt_en === 1'b1 && cnt_up !== exp_dir) dir_err <= dir_err + 1;
    end
    assign cnt_value = mcnt;

    typedef struct {
        int steps;
        int abrt;
        int cyc;
        int en0;
        int clr0;
        int clr;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_done = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, req);
        end
    endtask

    // Advance to the next falling edge and score any done pulse seen there.
    task automatic tick();
        exp_t e;
        @(negedge Clk);
        if (done !== 1'b0) begin
            if (sb.size() == 0) begin
                chk("spurious_done", {31'd0, done}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("steps", {27'd0, steps}, e.steps);
                chk("aborted", {31'd0, aborted}, e.abrt);
                chk("en_pulses", en_tot - e.en0, e.steps);
                chk("clr_pulses", clr_tot - e.clr0, e.clr);
            end
            n_done++;
        end
    endtask

    task automatic load(input logic [WIDTH-1:0] v);
        ld = 1'b1; ld_val = v;
        tick();
        ld = 1'b0;
    endtask

    // Present one command; d is the step distance. done is visible after
    // edge T+d*S+1 (+1 with clear), i.e. captured by the edge one later.
    task automatic issue(input logic up, input logic clr, input logic [WIDTH-1:0] tgt,
                         input int nsteps, input int abrt, input int d, input bit push);
        exp_t e;
        cmd_up = up; cmd_clear = clr; cmd_target = tgt; cmd_valid = 1'b1;
        exp_dir = up;
        chk("cmd_ready", {31'd0, cmd_ready}, 32'd1);
        e.steps = nsteps; e.abrt = abrt; e.en0 = en_tot; e.clr0 = clr_tot;
        e.clr = clr ? 1 : 0;
        e.cyc = (cyc + 1) + d * S + 1 + e.clr;
        if (push) sb.push_back(e);
        tick();
        cmd_valid = 1'b0;
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done(input int bound);
        int goal = n_done + 1;
        int k = 0;
        while (n_done < goal && k < bound) begin
            tick();
            k++;
        end
        if (n_done < goal) chk("done_timeout", {31'd0, done}, 32'd1);
    endtask

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b1; cmd_up = 1'b0; cmd_clear = 1'b0;
        cmd_target = '0; abort = 1'b0; ld = 1'b1; ld_val = '0; exp_dir = 1'b0;

        // Reset state, with cmd_valid held high.
        tick(); tick();
        chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_aborted", {31'd0, aborted}, 32'd0);
        chk("rst_steps", {27'd0, steps}, 32'd0);
        chk("rst_cnt_en", {31'd0, cnt_en}, 32'd0);
        chk("rst_cnt_clr", {31'd0, cnt_clr}, 32'd0);
        reset_n = 1'b1; cmd_valid = 1'b0; ld = 1'b0;
        tick();
        chk("idle_ready", {31'd0, cmd_ready}, 32'd1);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // 1: up 3 -> 5.
        load(4'd3);
        issue(1'b1, 1'b0, 4'd5, 2, 0, 2, 1'b1);
`ifndef COUNT_PRESCALE_EN
        chk("t1_cnt_en", {31'd0, cnt_en}, 32'd1);
        chk("t1_cnt_up", {31'd0, cnt_up}, 32'd1);
`endif
        wait_done(100);
        chk("t1_final", {28'd0, cnt_value}, 32'd5);
        tick();
        chk("t1_ready_after", {31'd0, cmd_ready}, 32'd1);

        // 2: down 1 -> 14, wraps through 0 and 15.
        load(4'd1);
        issue(1'b0, 1'b0, 4'd14, 3, 0, 3, 1'b1);
        wait_done(100);
        chk("t2_final", {28'd0, cnt_value}, 32'd14);

        // 3: clear then up to 0: one clear cycle, zero steps.
        load(4'd9);
        issue(1'b1, 1'b1, 4'd0, 0, 0, 0, 1'b1);
        chk("t3_cnt_clr", {31'd0, cnt_clr}, 32'd1);
        chk("t3_cnt_en", {31'd0, cnt_en}, 32'd0);
        wait_done(100);
        chk("t3_final", {28'd0, cnt_value}, 32'd0);

        // 4: up 0 -> 10, abort after 4 steps.
        load(4'd0);
        issue(1'b1, 1'b0, 4'd10, 4, 1, 4, 1'b1);
        repeat (4 * S) tick();
        abort = 1'b1;
        #1;
        chk("t4_no_5th_step", {31'd0, cnt_en}, 32'd0);
        tick();
        abort = 1'b0;
        chk("t4_done_seen", {31'd0, done}, 32'd1);
        tick();
        chk("t4_ready_after", {31'd0, cmd_ready}, 32'd1);
        chk("t4_final", {28'd0, cnt_value}, 32'd4);
        chk("t4_aborted_held", {31'd0, aborted}, 32'd1);

        // 5: up wraps 14 -> 15 -> 0 -> 1.
        load(4'd14);
        issue(1'b1, 1'b0, 4'd1, 3, 0, 3, 1'b1);
        wait_done(100);
        chk("t5_final", {28'd0, cnt_value}, 32'd1);

        // 6: already at target: zero steps, done next cycle.
        load(4'd7);
        issue(1'b0, 1'b0, 4'd7, 0, 0, 0, 1'b1);
        wait_done(100);
        chk("t6_aborted", {31'd0, aborted}, 32'd0);

        // 7: up 2 -> 4 (PRESCALE cycles per step in the prescaled build).
        load(4'd2);
        issue(1'b1, 1'b0, 4'd4, 2, 0, 2, 1'b1);
        wait_done(100);
        chk("t7_final", {28'd0, cnt_value}, 32'd4);

        // 8: reset during RUN; a held cmd_valid must not be accepted.
        load(4'd0);
        issue(1'b1, 1'b0, 4'd10, 0, 0, 10, 1'b0);
        repeat (3 * S) tick();
        reset_n = 1'b0; cmd_valid = 1'b1; cmd_target = 4'd3;
        tick();
        chk("t8_busy", {31'd0, busy}, 32'd0);
        chk("t8_cnt_en", {31'd0, cnt_en}, 32'd0);
        chk("t8_steps", {27'd0, steps}, 32'd0);
        chk("t8_done", {31'd0, done}, 32'd0);
        chk("t8_ready", {31'd0, cmd_ready}, 32'd0);
        tick();
        chk("t8_busy_hold", {31'd0, busy}, 32'd0);
        reset_n = 1'b1; cmd_valid = 1'b0;
        tick();
        chk("t8_idle_busy", {31'd0, busy}, 32'd0);
        chk("t8_idle_ready", {31'd0, cmd_ready}, 32'd1);

        // 9: abort in IDLE is ignored.
        abort = 1'b1;
        tick(); tick();
        abort = 1'b0;
        chk("t9_busy", {31'd0, busy}, 32'd0);
        chk("t9_aborted", {31'd0, aborted}, 32'd0);

        chk("sb_empty", sb.size(), 32'd0);
        chk("dir_errors", dir_err, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
